mc_controller: RTL
==================

# mc_controller

Multicycle control unit for the arfcpu datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives every datapath mux select and write enable. It also drives the 3-bit `alucontrol` code consumed by `alu.op`, making it the producer end of the ALU op interface. Moore FSM plus a combinational ALU-op decoder, sitting between the instruction register and the datapath.

## Interface
- No parameters; encodings below are fixed.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 6: instr[31:26] from instruction register.
- `funct` in 6: instr[5:0].
- `zero` in 1: ALU zero flag.
- `pcen` out 1: PC write enable = `pcwrite | (branch & zero)`.
- `irwrite` out 1: instruction register load.
- `memwrite` out 1: data memory write.
- `regwrite` out 1: register file write.
- `iord` out 1: memory address select (0 = PC, 1 = ALUOut).
- `memtoreg` out 1: writeback select (0 = ALUOut, 1 = Data).
- `regdst` out 1: destination select (0 = rt, 1 = rd).
- `alusrca` out 1: ALU A select (0 = PC, 1 = A).
- `alusrcb` out 2: ALU B select (00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2).
- `pcsrc` out 2: PC source (00 = ALUResult, 01 = ALUOut, 10 = jump target).
- `alucontrol` out 3: ALU op (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT).
- `state` out 4: current state, for debug and verification.

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
- Internal `aluop[1:0]`, `pcwrite` and `branch` are state-decoded. Every control signal not listed for a state is 0.
- FETCH: `irwrite`=1, `pcwrite`=1, `alusrcb`=01, `aluop`=00. Next state: DECODE.
- DECODE: `alusrcb`=11, `aluop`=00. Next state by `op`:
  - 100011 (lw) or 101011 (sw) -> MEMADR.
  - 000000 -> RTYPEEX.
  - 000100 -> BEQEX.
  - 001000 -> ADDIEX.
  - 000010 -> JEX.
  - Any other `op` -> FETCH (silent no-op).
- MEMADR: `alusrca`=1, `alusrcb`=10, `aluop`=00. Next state: MEMRD if `op`=100011, else MEMWR.
- MEMRD: `iord`=1. Next state: MEMWB.
- MEMWB: `memtoreg`=1, `regwrite`=1. Next state: FETCH.
- MEMWR: `iord`=1, `memwrite`=1. Next state: FETCH.
- RTYPEEX: `alusrca`=1, `alusrcb`=00, `aluop`=10. Next state: RTYPEWB.
- RTYPEWB: `regdst`=1, `regwrite`=1. Next state: FETCH.
- BEQEX: `alusrca`=1, `aluop`=01, `pcsrc`=01, `branch`=1. Next state: FETCH.
- ADDIEX: `alusrca`=1, `alusrcb`=10, `aluop`=00. Next state: ADDIWB.
- ADDIWB: `regwrite`=1. Next state: FETCH.
- JEX: `pcsrc`=10, `pcwrite`=1. Next state: FETCH.
- Encodings 12-15: all outputs 0, next state FETCH.
- ALU decode (combinational):
  - `aluop` 00 -> 010.
  - `aluop` 01 -> 110.
  - `aluop` 11 -> 010.
  - `aluop` 10, decoded by `funct`: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other -> 000.
- `op` and `funct` are sampled live each cycle. The IR holds them stable after FETCH.

## Timing
- `reset` high at a rising edge: `state` becomes FETCH (0) on that edge.
- While `reset` is high, `pcen`, `irwrite`, `memwrite` and `regwrite` are forced to 0 combinationally. All other outputs follow the FETCH decode: `alusrcb`=01, `alucontrol`=010, rest 0.
- Reset asserted mid-instruction: aborts the instruction. No write enable pulses after the asserting edge. Execution restarts at FETCH the cycle after `reset` deasserts.
- Exactly one state transition per clock. Outputs change only after a clock edge, except `pcen` (follows `zero`) and `alucontrol` (follows `funct`).
- Cycles per instruction, FETCH through last state inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unsupported `op` 2.
- `regwrite`, `memwrite` and `irwrite` are single-cycle pulses per instruction.
- `pcen` is high in FETCH, in JEX, and in BEQEX only when `zero`=1.

## Test plan
- **Reset:** hold `reset` 2 cycles from an arbitrary state (e.g. mid-lw in MEMRD) -> `state`=0 after the first edge, all write enables 0 while reset is high. After release: `irwrite`=1, `pcen`=1, `alucontrol`=010.
- **lw:** `op`=100011 -> states 0,1,2,3,4,0. `iord`=1 in MEMRD. `regwrite`=1 with `memtoreg`=1 and `regdst`=0 in MEMWB only.
- **sw:** `op`=101011 -> states 0,1,2,5,0. `memwrite`=1 for exactly one cycle. `regwrite` never 1.
- **R-type sweep:** `op`=0 with `funct` in turn 100100, 100101, 100000, 100010, 101010, 000111 -> `alucontrol` in RTYPEEX is 000, 001, 010, 110, 111, 000. RTYPEWB has `regdst`=1, `regwrite`=1.
- **beq and j:** `op`=000100 with `zero`=1 -> BEQEX has `pcen`=1, `pcsrc`=01, `alucontrol`=110. Same with `zero`=0 -> `pcen`=0. `op`=000010 -> JEX has `pcen`=1, `pcsrc`=10; 3 cycles total.
- **addi and illegal:** `op`=001000 -> states 0,1,9,10,0 with `alusrcb`=10 in ADDIEX. `op`=111111 -> states 0,1,0 with no write enable except FETCH's.

Source files
------------

// File: rtl/mc_controller.sv
// mc_controller: multicycle control unit for the arfcpu datapath.
// Moore FSM sequencing fetch/decode/execute/memory/writeback, plus a
// combinational ALU-op decoder that produces alucontrol for the ALU.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     state_q, state_d;
  state_t     dec_state;
  logic       pcwrite, branch;
  logic       irwrite_c, memwrite_c, regwrite_c;
  logic [1:0] aluop;

  // While reset is held the outputs present the FETCH decode, so the
  // datapath sees a benign configuration even before the reset edge.
  assign dec_state = reset ? FETCH : state_q;

  // State register: reset forces FETCH, otherwise one transition per clock.
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic and Moore output decode of the current state.
  always_comb begin
    state_d    = FETCH;
    irwrite_c  = 1'b0;
    memwrite_c = 1'b0;
    regwrite_c = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = 2'b00;
    case (dec_state)
      FETCH: begin
        irwrite_c = 1'b1;
        pcwrite   = 1'b1;
        alusrcb   = 2'b01;
        state_d   = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_c = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_c = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = RTYPEWB;
      end
      RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_c = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        regwrite_c = 1'b1;
      end
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // ALU-op decoder: R-type instructions select the operation from funct.
  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      2'b00: alucontrol = 3'b010;
      2'b01: alucontrol = 3'b110;
      2'b11: alucontrol = 3'b010;
      default: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b000;
        endcase
      end
    endcase
  end

  // Write enables are suppressed for as long as reset is asserted.
  assign irwrite  = irwrite_c  & ~reset;
  assign memwrite = memwrite_c & ~reset;
  assign regwrite = regwrite_c & ~reset;
  assign pcen     = (pcwrite | (branch & zero)) & ~reset;
  assign state    = state_q;

endmodule
